sd_clock_ctrl: RTL and testbench
================================

Name: sd_clock_ctrl

Overview:
- Sequences the SD clock divider on behalf of the host-controller register block.
- Holds the divider in reset while the internal clock is disabled, and loads the divisor only while the divider is held.
- Waits a fixed settle time before asserting internal-clock-stable.
- Gates the card clock on and off only during its low phase, and only when the CMD/DAT engines are idle.
- Sits between the Clock Control register fields and the divider/clock-gate cells, all in the AXI_CLOCK domain.

Parameters:
- STABLE_CYCLES, 16: AXI_CLOCK cycles from divider reset release to int_clk_stable=1; legal range 1..65535.
- RST_CYCLES, 4: cycles the divider is held in reset during a divisor reload; legal range 1..255.
- DRAIN_TIMEOUT, 4096: maximum cycles spent waiting for bus idle before the clock is forced off; legal range 1..65535.

Ports:
- AXI_CLOCK, in, 1: sole clock.
- AXI_RST, in, 1: synchronous, active-high reset.
- int_clk_en, in, 1: Clock Control internal clock enable.
- sd_clk_en, in, 1: Clock Control SD clock enable.
- freq_sel, in, 8: requested divisor.
- cmd_busy, in, 1: CMD engine mid-transaction.
- dat_busy, in, 1: DAT engine mid-transaction.
- sd_clk_i, in, 1: divider output, sampled to find its low phase.
- divisor_o, out, 8: divisor driven to the divider.
- div_rst_o, out, 1: active-high hold-reset to the divider.
- sd_clk_gate_o, out, 1: card-clock gate enable.
- int_clk_stable, out, 1: Present/Clock status bit.
- clk_change_done, out, 1: one-cycle pulse on each STARTUP->STABLE transition.
- drain_timeout_err, out, 1: one-cycle pulse when the drain is forced.

Behaviour:
- Reset (AXI_RST=1 at a clock edge), regardless of state:
  - state=OFF, divisor_o=0, div_rst_o=1, sd_clk_gate_o=0, int_clk_stable=0, both pulses 0, counters 0.
- All outputs are registered.
- States: OFF, STARTUP, STABLE, RUN, DRAIN, RELOAD.
- OFF:
  - div_rst_o=1, int_clk_stable=0, gate=0.
  - On int_clk_en=1: divisor_o<=freq_sel, go STARTUP, cnt<=0.
- STARTUP:
  - div_rst_o=0; cnt increments each cycle.
  - When cnt==STABLE_CYCLES-1: next cycle int_clk_stable=1, clk_change_done pulses, go STABLE.
  - int_clk_en=0 aborts to OFF immediately.
  - freq_sel changes are ignored here and are re-evaluated in STABLE.
- STABLE (gate=0). Priority order:
  1. int_clk_en=0 -> OFF.
  2. freq_sel!=divisor_o -> RELOAD.
  3. sd_clk_en=1 -> RUN.
- RUN:
  - Gate request is asserted; sd_clk_gate_o rises only on a cycle where the registered sd_clk_i sample is 0.
  - Any of int_clk_en=0, sd_clk_en=0, or freq_sel!=divisor_o -> DRAIN, dcnt<=0.
- DRAIN:
  - Gate stays 1 while cmd_busy|dat_busy.
  - Once both are 0 and the registered sd_clk_i sample is 0: gate<=0, go STABLE, which then applies the pending cause by its priority.
  - If dcnt reaches DRAIN_TIMEOUT-1: drain_timeout_err pulses, then the same low-phase rule applies to gating off.
  - A cause that is withdrawn while in DRAIN (e.g. sd_clk_en returns to 1 with no freq change) still completes the gate-off; RUN is re-entered via STABLE.
- RELOAD:
  - int_clk_stable<=0, div_rst_o=1 for RST_CYCLES cycles.
  - divisor_o<=freq_sel on the final cycle; freq_sel is sampled at that cycle.
  - Then STARTUP.
- Invariants:
  - div_rst_o=1 in OFF/RELOAD.
  - divisor_o changes only while div_rst_o=1.
  - sd_clk_gate_o=1 only in RUN/DRAIN.
  - sd_clk_gate_o changes only when the sampled sd_clk_i=0.
  - int_clk_stable=1 only in STABLE/RUN/DRAIN.
- Simultaneous events:
  - int_clk_en drop outranks a frequency change.
  - Reset outranks everything.
  - A reset mid-DRAIN drops the gate with no wait for bus idle.
- Counter widths: 16-bit cnt/dcnt. freq_sel==0 is legal and passed through unchanged.

Test Plan:
- Reset, int_clk_en=1, freq_sel=8'h04:
  - divisor_o=4 one cycle after enable.
  - div_rst_o falls one cycle after enable.
  - int_clk_stable and clk_change_done rise exactly 16 cycles after div_rst_o falls; the pulse is one cycle wide.
- From STABLE, sd_clk_en=1 with sd_clk_i toggling every 5 cycles:
  - sd_clk_gate_o rises only on a cycle following a sampled sd_clk_i=0.
  - It never rises while the sample is 1.
- In RUN with dat_busy=1, change freq_sel to 8'h01, hold busy 50 cycles:
  - gate stays 1 for those 50 cycles, then drops at sd_clk low.
  - div_rst_o=1 for 4 cycles; divisor_o=1; stable reasserts after 16 cycles.
  - gate returns to 1 because sd_clk_en is still 1.
- In RUN, hold cmd_busy=1 permanently and clear sd_clk_en:
  - drain_timeout_err pulses once after 4096 cycles.
  - gate falls at the next low phase; state becomes STABLE.
- In RUN, drop int_clk_en and change freq_sel in the same cycle:
  - after the drain the block enters OFF, not RELOAD.
  - div_rst_o=1, int_clk_stable=0.
- Assert AXI_RST mid-STARTUP and separately mid-DRAIN with busy=1:
  - the next cycle shows all reset values, gate=0, and no pulses.

Source files
------------

// File: rtl/sd_clock_ctrl.sv
// sd_clock_ctrl: sequences the SD clock divider and the card-clock gate for
// the host-controller Clock Control fields, entirely in the AXI_CLOCK domain.
// Divisor loads only while the divider is held in reset, and the card clock
// is gated on/off only during its sampled low phase.
module sd_clock_ctrl #(
    parameter int STABLE_CYCLES = 16,
    parameter int RST_CYCLES    = 4,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic       AXI_CLOCK,
    input  logic       AXI_RST,
    input  logic       int_clk_en,
    input  logic       sd_clk_en,
    input  logic [7:0] freq_sel,
    input  logic       cmd_busy,
    input  logic       dat_busy,
    input  logic       sd_clk_i,
    output logic [7:0] divisor_o,
    output logic       div_rst_o,
    output logic       sd_clk_gate_o,
    output logic       int_clk_stable,
    output logic       clk_change_done,
    output logic       drain_timeout_err
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_STARTUP,
        ST_STABLE,
        ST_RUN,
        ST_DRAIN,
        ST_RELOAD
    } state_t;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  divisor_q, divisor_d;
    logic        divRst_q, divRst_d;
    logic        gate_q, gate_d;
    logic        stable_q, stable_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        forced_q, forced_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic        sample_q;

    logic        freqChange;
    logic        busyAny;

    assign freqChange = (freq_sel != divisor_q);
    assign busyAny    = cmd_busy | dat_busy;

    // Registered copy of the divider output, used to find its low phase.
    always_ff @(posedge AXI_CLOCK) begin
        sample_q <= sd_clk_i;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge AXI_CLOCK) begin
        if (AXI_RST) begin
            state_q   <= ST_OFF;
            divisor_q <= 8'd0;
            divRst_q  <= 1'b1;
            gate_q    <= 1'b0;
            stable_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            forced_q  <= 1'b0;
            cnt_q     <= 16'd0;
            dcnt_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            divRst_q  <= divRst_d;
            gate_q    <= gate_d;
            stable_q  <= stable_d;
            done_q    <= done_d;
            err_q     <= err_d;
            forced_q  <= forced_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
        end
    end

    // Next-state logic; divider reset and stable flag follow the next state.
    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        gate_d    = gate_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        forced_d  = forced_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        divRst_d  = 1'b1;
        stable_d  = 1'b0;

        case (state_q)
            ST_OFF: begin
                gate_d = 1'b0;
                if (int_clk_en) begin
                    divisor_d = freq_sel;
                    state_d   = ST_STARTUP;
                    cnt_d     = 16'd0;
                end
            end
            ST_STARTUP: begin
                if (!int_clk_en) begin
                    state_d = ST_OFF;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_STABLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STABLE: begin
                gate_d = 1'b0;
                if (!int_clk_en) begin
                    state_d = ST_OFF;
                end else if (freqChange) begin
                    state_d = ST_RELOAD;
                    cnt_d   = 16'd0;
                end else if (sd_clk_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!int_clk_en || !sd_clk_en || freqChange) begin
                    state_d  = ST_DRAIN;
                    dcnt_d   = 16'd0;
                    forced_d = 1'b0;
                end else if (!gate_q && !sample_q) begin
                    gate_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if ((!busyAny || forced_q) && !sample_q) begin
                    gate_d  = 1'b0;
                    state_d = ST_STABLE;
                end else if (!forced_q) begin
                    if (dcnt_q == DRAIN_LAST) begin
                        err_d    = 1'b1;
                        forced_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 16'd1;
                    end
                end
            end
            ST_RELOAD: begin
                if (cnt_q == RST_LAST) begin
                    divisor_d = freq_sel;
                    state_d   = ST_STARTUP;
                    cnt_d     = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_OFF;
                gate_d  = 1'b0;
            end
        endcase

        divRst_d = (state_d == ST_OFF) || (state_d == ST_RELOAD);
        stable_d = (state_d == ST_STABLE) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    assign divisor_o         = divisor_q;
    assign div_rst_o         = divRst_q;
    assign sd_clk_gate_o     = gate_q;
    assign int_clk_stable    = stable_q;
    assign clk_change_done   = done_q;
    assign drain_timeout_err = err_q;

endmodule

// File: tb/tb_sd_clock_ctrl.sv
// tb_sd_clock_ctrl: directed scenarios plus randomized stimulus, checked every
// cycle against a timestamp-based behavioural model of the clock sequencer.
module tb_sd_clock_ctrl;

    localparam int STABLE_CYCLES = 16;
    localparam int RST_CYCLES    = 4;
    localparam int DRAIN_TIMEOUT = 4096;

    localparam int M_OFF     = 0;
    localparam int M_STARTUP = 1;
    localparam int M_STABLE  = 2;
    localparam int M_RUN     = 3;
    localparam int M_DRAIN   = 4;
    localparam int M_RELOAD  = 5;

    logic       AXI_CLOCK = 1'b0;
    logic       AXI_RST;
    logic       int_clk_en;
    logic       sd_clk_en;
    logic [7:0] freq_sel;
    logic       cmd_busy;
    logic       dat_busy;
    logic       sd_clk_i;
    logic [7:0] divisor_o;
    logic       div_rst_o;
    logic       sd_clk_gate_o;
    logic       int_clk_stable;
    logic       clk_change_done;
    logic       drain_timeout_err;

    int testsRun    = 0;
    int testsFailed = 0;
    int sdMode      = 1;

    // Model state: mode plus absolute cycle deadlines instead of counters.
    int         cyc        = 0;
    int         mMode      = M_OFF;
    logic [7:0] mDivisor   = 8'd0;
    logic       mGate      = 1'b0;
    logic       mDone      = 1'b0;
    logic       mErr       = 1'b0;
    logic       mForced    = 1'b0;
    logic       mSample    = 1'b0;
    logic       mValid     = 1'b0;
    logic       sampleUsed = 1'b0;
    logic       rstAtEdge  = 1'b0;
    logic       lastGate   = 1'b0;
    int         startupEnd = 0;
    int         reloadEnd  = 0;
    int         drainStart = 0;

    sd_clock_ctrl #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .RST_CYCLES(RST_CYCLES),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .AXI_CLOCK(AXI_CLOCK),
        .AXI_RST(AXI_RST),
        .int_clk_en(int_clk_en),
        .sd_clk_en(sd_clk_en),
        .freq_sel(freq_sel),
        .cmd_busy(cmd_busy),
        .dat_busy(dat_busy),
        .sd_clk_i(sd_clk_i),
        .divisor_o(divisor_o),
        .div_rst_o(div_rst_o),
        .sd_clk_gate_o(sd_clk_gate_o),
        .int_clk_stable(int_clk_stable),
        .clk_change_done(clk_change_done),
        .drain_timeout_err(drain_timeout_err)
    );

    always #5 AXI_CLOCK = ~AXI_CLOCK;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge AXI_CLOCK);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic sdEn, input logic [7:0] freq,
                                 input logic cmdB, input logic datB, input logic rst);
        int_clk_en = en;
        sd_clk_en  = sdEn;
        freq_sel   = freq;
        cmd_busy   = cmdB;
        dat_busy   = datB;
        AXI_RST    = rst;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " divisor"}, 16'(divisor_o), 16'h0);
        checkOutput({tag, " div_rst"}, 16'(div_rst_o), 16'h1);
        checkOutput({tag, " gate"}, 16'(sd_clk_gate_o), 16'h0);
        checkOutput({tag, " stable"}, 16'(int_clk_stable), 16'h0);
        checkOutput({tag, " done"}, 16'(clk_change_done), 16'h0);
        checkOutput({tag, " err"}, 16'(drain_timeout_err), 16'h0);
    endtask

    task automatic waitGate(input logic val, input int limit, input string name);
        int n = 0;
        while (sd_clk_gate_o !== val && n < limit) begin
            tick();
            n++;
        end
        checkOutput(name, 16'(sd_clk_gate_o), 16'(val));
    endtask

    // Divider output: toggles every 5 cycles, or random per cycle.
    initial begin
        int sdCnt = 0;
        sd_clk_i = 1'b0;
        forever begin
            @(posedge AXI_CLOCK);
            #1;
            if (sdMode == 0) begin
                sd_clk_i = 1'($urandom_range(0, 1));
            end else if (sdCnt == 4) begin
                sdCnt    = 0;
                sd_clk_i = ~sd_clk_i;
            end else begin
                sdCnt++;
            end
        end
    end

    // Behavioural model, advanced on each rising edge.
    initial begin
        forever begin
            @(posedge AXI_CLOCK);
            sampleUsed = mSample;
            rstAtEdge  = AXI_RST;
            cyc++;
            mDone = 1'b0;
            mErr  = 1'b0;
            if (AXI_RST) begin
                mMode    = M_OFF;
                mDivisor = 8'd0;
                mGate    = 1'b0;
                mForced  = 1'b0;
                mValid   = 1'b1;
            end else if (mValid) begin
                case (mMode)
                    M_OFF: if (int_clk_en) begin
                        mDivisor   = freq_sel;
                        mMode      = M_STARTUP;
                        startupEnd = cyc + STABLE_CYCLES;
                    end
                    M_STARTUP: if (!int_clk_en) begin
                        mMode = M_OFF;
                    end else if (cyc == startupEnd) begin
                        mMode = M_STABLE;
                        mDone = 1'b1;
                    end
                    M_STABLE: if (!int_clk_en) begin
                        mMode = M_OFF;
                    end else if (freq_sel != mDivisor) begin
                        mMode     = M_RELOAD;
                        reloadEnd = cyc + RST_CYCLES;
                    end else if (sd_clk_en) begin
                        mMode = M_RUN;
                    end
                    M_RUN: if (!int_clk_en || !sd_clk_en || freq_sel != mDivisor) begin
                        mMode      = M_DRAIN;
                        drainStart = cyc;
                        mForced    = 1'b0;
                    end else if (!mGate && !mSample) begin
                        mGate = 1'b1;
                    end
                    M_DRAIN: if ((!(cmd_busy || dat_busy) || mForced) && !mSample) begin
                        mGate = 1'b0;
                        mMode = M_STABLE;
                    end else if (!mForced && cyc == drainStart + DRAIN_TIMEOUT) begin
                        mErr    = 1'b1;
                        mForced = 1'b1;
                    end
                    M_RELOAD: if (cyc == reloadEnd) begin
                        mDivisor   = freq_sel;
                        mMode      = M_STARTUP;
                        startupEnd = cyc + STABLE_CYCLES;
                    end
                    default: mMode = M_OFF;
                endcase
            end
            mSample = sd_clk_i;
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge AXI_CLOCK);
            if (mValid) begin
                checkOutput("divisor_o", 16'(divisor_o), 16'(mDivisor));
                checkOutput("div_rst_o", 16'(div_rst_o), 16'(mMode == M_OFF || mMode == M_RELOAD));
                checkOutput("sd_clk_gate_o", 16'(sd_clk_gate_o), 16'(mGate));
                checkOutput("int_clk_stable", 16'(int_clk_stable),
                            16'(mMode == M_STABLE || mMode == M_RUN || mMode == M_DRAIN));
                checkOutput("clk_change_done", 16'(clk_change_done), 16'(mDone));
                checkOutput("drain_timeout_err", 16'(drain_timeout_err), 16'(mErr));
                if (sd_clk_gate_o !== lastGate && !rstAtEdge) begin
                    checkOutput("gate edge at low phase", 16'(sampleUsed), 16'h0);
                end
                lastGate = sd_clk_gate_o;
            end
        end
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        int n;
        int hold;
        logic en, sdEn, cmdB, datB, rst;
        logic [7:0] freq;

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        checkResetValues("reset");
        AXI_RST = 1'b0;
        tick();

        // Power up with divisor 4.
        applyStimulus(1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("divisor after enable", 16'(divisor_o), 16'h4);
        checkOutput("div_rst after enable", 16'(div_rst_o), 16'h0);
        n = 0;
        while (int_clk_stable !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("cycles to stable", 16'(n), 16'd16);
        checkOutput("done pulse high", 16'(clk_change_done), 16'h1);
        tick();
        checkOutput("done pulse width", 16'(clk_change_done), 16'h0);

        // Card clock on.
        sd_clk_en = 1'b1;
        waitGate(1'b1, 30, "gate on");

        // Frequency change while DAT is busy.
        dat_busy = 1'b1;
        freq_sel = 8'h01;
        hold = 0;
        repeat (50) begin
            tick();
            if (sd_clk_gate_o === 1'b1) hold++;
        end
        checkOutput("gate held while busy", 16'(hold), 16'd50);
        dat_busy = 1'b0;
        waitGate(1'b0, 20, "gate off after drain");
        n = 0;
        while (div_rst_o !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        n = 0;
        while (div_rst_o === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checkOutput("reload hold cycles", 16'(n), 16'd4);
        checkOutput("divisor after reload", 16'(divisor_o), 16'h1);
        n = 0;
        while (int_clk_stable !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("restable cycles", 16'(n), 16'd16);
        waitGate(1'b1, 30, "gate back on");

        // Drain timeout with CMD stuck busy.
        cmd_busy  = 1'b1;
        sd_clk_en = 1'b0;
        n = 0;
        while (drain_timeout_err !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        checkOutput("timeout latency", 16'(n), 16'd4097);
        tick();
        checkOutput("timeout pulse width", 16'(drain_timeout_err), 16'h0);
        waitGate(1'b0, 20, "gate off after timeout");
        tick();
        checkOutput("stable after timeout", 16'(int_clk_stable), 16'h1);
        cmd_busy = 1'b0;

        // Enable drop and frequency change together.
        sd_clk_en = 1'b1;
        waitGate(1'b1, 40, "gate on again");
        int_clk_en = 1'b0;
        freq_sel   = 8'h33;
        waitGate(1'b0, 20, "gate off on disable");
        repeat (2) tick();
        checkOutput("off div_rst", 16'(div_rst_o), 16'h1);
        checkOutput("off stable", 16'(int_clk_stable), 16'h0);
        checkOutput("off keeps divisor", 16'(divisor_o), 16'h1);

        // Reset during STARTUP.
        applyStimulus(1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        checkOutput("startup div_rst", 16'(div_rst_o), 16'h0);
        AXI_RST = 1'b1;
        tick();
        checkResetValues("reset mid-startup");
        AXI_RST = 1'b0;

        // Reset during DRAIN with busy.
        applyStimulus(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        waitGate(1'b1, 60, "gate on before drain reset");
        dat_busy  = 1'b1;
        sd_clk_en = 1'b0;
        repeat (3) tick();
        checkOutput("gate held in drain", 16'(sd_clk_gate_o), 16'h1);
        AXI_RST = 1'b1;
        tick();
        checkResetValues("reset mid-drain");
        AXI_RST = 1'b0;

        // Randomized phase.
        sdMode = 0;
        en = 1'b1; sdEn = 1'b1; freq = 8'h02; cmdB = 1'b0; datB = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) sdEn = ~sdEn;
            if ($urandom_range(0, 99) == 0) freq = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) cmdB = ~cmdB;
            if ($urandom_range(0, 7) == 0) datB = ~datB;
            rst = ($urandom_range(0, 599) == 0);
            applyStimulus(en, sdEn, freq, cmdB, datB, rst);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
